pot_scan_ctrl: RTL

- Parametrised successor to the fixed 6-pot slide interface.
- Round-robin scans NUM_CH analog channels through the existing A2D interface using a strt_cnv/cnv_cmplt handshake, and holds one RES_W-bit value per channel.
- Detects conversion timeouts and raises a sticky ready flag after WARMUP_SCANS complete scans.
- Sits between A2D_intf and EQ_Engine; ready directly gates AMP_ON.

---
 rtl/eq_pkg.sv | 20 ++
 rtl/pot_scan_ctrl_if.sv | 13 +
 rtl/pot_filter.sv | 56 +++++
 rtl/pot_scan_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared types and default timing constants for the pot scan controller.
package eq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GAP   = 2'd1,
      START = 2'd2,
      WAIT  = 2'd3
   } scan_state_e;

   localparam int SCAN_GAP_DEF     = 16;
   localparam int TIMEOUT_DEF      = 1024;
   localparam int WARMUP_SCANS_DEF = 2;

   // Bits needed for a counter spanning 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pot_scan_ctrl_if.sv
// A2D conversion handshake: start/channel out from the scanner, done/result back.
interface pot_scan_ctrl_if #(
   parameter int RES_W  = 12,
   parameter int CHNL_W = 3
);
   logic              strt_cnv;
   logic [CHNL_W-1:0] chnnl;
   logic              cnv_cmplt;
   logic [RES_W-1:0]  res;

   modport master (output strt_cnv, chnnl, input cnv_cmplt, res);
   modport slave  (input strt_cnv, chnnl, output cnv_cmplt, res);
endinterface

// File: rtl/pot_filter.sv
// Per-channel value store. With POT_FILTER_EN defined it is a 1/4-weight IIR
// whose first load after reset takes the sample directly; otherwise a plain register.
module pot_filter #(
   parameter int RES_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [RES_W-1:0] res,
   output logic [RES_W-1:0] value
);

`ifdef POT_FILTER_EN
   logic [RES_W-1:0]  value_q, value_d;
   logic              primed_q, primed_d;
   logic signed [RES_W:0] diff;
   logic signed [RES_W:0] step;

   always_comb begin
      value_d  = value_q;
      primed_d = primed_q;
      diff     = $signed({1'b0, res}) - $signed({1'b0, value_q});
      step     = diff >>> 2;
      if (load) begin
         primed_d = 1'b1;
         // Sum wraps to RES_W bits; the step magnitude never exceeds the gap.
         value_d  = primed_q ? (value_q + RES_W'(step)) : res;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q  <= '0;
         primed_q <= 1'b0;
      end else begin
         value_q  <= value_d;
         primed_q <= primed_d;
      end
   end
`else
   logic [RES_W-1:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (load) value_d = res;
   end

   always_ff @(posedge clk) begin
      if (rst) value_q <= '0;
      else     value_q <= value_d;
   end
`endif

   assign value = value_q;

endmodule

// File: rtl/pot_scan_ctrl.sv
// Round-robin A2D scanner holding one value per channel; optional smoothing
// in pot_filter is selected by the POT_FILTER_EN macro.
//
//   state | meaning
//   IDLE  | one cycle after reset, loads the gap timer
//   GAP   | idle SCAN_GAP cycles between conversions
//   START | strt_cnv pulse, arms the timeout timer
//   WAIT  | waiting for cnv_cmplt or timeout, then advance channel
module pot_scan_ctrl
   import eq_pkg::*;
#(
   parameter int NUM_CH       = 6,
   parameter int RES_W        = 12,
   parameter int CHNL_W       = 3,
   parameter int SCAN_GAP     = SCAN_GAP_DEF,
   parameter int TIMEOUT      = TIMEOUT_DEF,
   parameter int WARMUP_SCANS = WARMUP_SCANS_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   pot_scan_ctrl_if.master         a2d,
   output logic [NUM_CH*RES_W-1:0] pot_val,
   output logic [NUM_CH-1:0]       pot_upd,
   output logic                    scan_done,
   output logic                    ready,
   output logic [NUM_CH-1:0]       to_err
);

   localparam int GAP_W = cnt_w(SCAN_GAP);
   localparam int TMO_W = cnt_w(TIMEOUT);
   localparam int SCN_W = cnt_w(WARMUP_SCANS + 1);

   localparam logic [GAP_W-1:0]  GAP_LD  = GAP_W'(SCAN_GAP - 1);
   localparam logic [TMO_W-1:0]  TMO_LD  = TMO_W'(TIMEOUT - 1);
   localparam logic [SCN_W-1:0]  SCN_MAX = SCN_W'(WARMUP_SCANS);
   localparam logic [CHNL_W-1:0] LAST_CH = CHNL_W'(NUM_CH - 1);

   scan_state_e       state_q, state_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic [CHNL_W-1:0] ch_q, ch_d;
   logic [SCN_W-1:0]  scan_cnt_q, scan_cnt_d;
   logic [NUM_CH-1:0] upd_q, upd_d;
   logic [NUM_CH-1:0] to_err_q, to_err_d;
   logic              scan_done_q, scan_done_d;
   logic              ready_q, ready_d;

   logic [NUM_CH-1:0] ch_onehot;
   logic [NUM_CH-1:0] load_vec;
   logic              advance;

   assign ch_onehot = NUM_CH'(1) << ch_q;

   always_comb begin
      state_d     = state_q;
      gap_cnt_d   = gap_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      ch_d        = ch_q;
      scan_cnt_d  = scan_cnt_q;
      upd_d       = '0;
      to_err_d    = to_err_q;
      scan_done_d = 1'b0;
      ready_d     = ready_q | (scan_cnt_q >= SCN_MAX);
      load_vec    = '0;
      advance     = 1'b0;

      case (state_q)
         IDLE: begin
            state_d   = GAP;
            gap_cnt_d = GAP_LD;
         end
         GAP: begin
            if (gap_cnt_q == '0) state_d = START;
            else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
         end
         START: begin
            state_d   = WAIT;
            tmo_cnt_d = TMO_LD;
         end
         WAIT: begin
            // A completion on the expiry cycle wins over the timeout.
            if (a2d.cnv_cmplt) begin
               load_vec = ch_onehot;
               upd_d    = ch_onehot;
               advance  = 1'b1;
            end else if (tmo_cnt_q == '0) begin
               to_err_d = to_err_q | ch_onehot;
               advance  = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (advance) begin
         state_d   = GAP;
         gap_cnt_d = GAP_LD;
         if (ch_q == LAST_CH) begin
            ch_d        = '0;
            scan_done_d = 1'b1;
            if (scan_cnt_q < SCN_MAX) scan_cnt_d = scan_cnt_q + SCN_W'(1);
         end else begin
            ch_d = ch_q + CHNL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gap_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
         ch_q        <= '0;
         scan_cnt_q  <= '0;
         upd_q       <= '0;
         to_err_q    <= '0;
         scan_done_q <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         gap_cnt_q   <= gap_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         ch_q        <= ch_d;
         scan_cnt_q  <= scan_cnt_d;
         upd_q       <= upd_d;
         to_err_q    <= to_err_d;
         scan_done_q <= scan_done_d;
         ready_q     <= ready_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      pot_filter #(.RES_W(RES_W)) u_filt (
         .clk   (clk),
         .rst   (rst),
         .load  (load_vec[g]),
         .res   (a2d.res),
         .value (pot_val[g*RES_W +: RES_W])
      );
   end

   assign a2d.strt_cnv = (state_q == START);
   assign a2d.chnnl    = ch_q;
   assign pot_upd      = upd_q;
   assign scan_done    = scan_done_q;
   assign ready        = ready_q;
   assign to_err       = to_err_q;

endmodule
